// File: rtl/mul_scheduler.sv
// Shares one 2-stage pipelined n x n multiplier between two requesters with round-robin grants.
// Optional per-op signed mode is enabled by defining MUL_SCHED_SIGNED_EN.
module mul_scheduler #(
    parameter int unsigned n = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [n-1:0]     req0_a,
    input  logic [n-1:0]     req0_b,
    input  logic             req0_signed,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [n-1:0]     req1_a,
    input  logic [n-1:0]     req1_b,
    input  logic             req1_signed,
    output logic             res_valid,
    output logic             res_id,
    output logic [2*n-1:0]   res_data
);

    localparam int unsigned prod_w = 2 * n;

    logic              last_grant;
    logic              grant0_c;
    logic              grant1_c;
    logic              accept_c;
    logic [n-1:0]      sel_a_c;
    logic [n-1:0]      sel_b_c;

    logic              s1_valid;
    logic              s1_id;
    logic [n-1:0]      s1_a;
    logic [n-1:0]      s1_b;
    logic [prod_w-1:0] a_ext_c;
    logic [prod_w-1:0] b_ext_c;
    logic [prod_w-1:0] prod_c;

    // Round-robin grant: on contention the port that lost the last accepted transfer wins.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                grant0_c = last_grant;
                grant1_c = !last_grant;
            end else begin
                grant0_c = req0_valid;
                grant1_c = req1_valid;
            end
        end
    end

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;
    assign accept_c   = grant0_c | grant1_c;
    assign sel_a_c    = grant1_c ? req1_a : req0_a;
    assign sel_b_c    = grant1_c ? req1_b : req0_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept_c) begin
            last_grant <= grant1_c;
        end
    end

`ifdef MUL_SCHED_SIGNED_EN
    logic s1_signed;
    logic sel_signed_c;

    assign sel_signed_c = grant1_c ? req1_signed : req0_signed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_signed <= 1'b0;
        end else if (accept_c) begin
            s1_signed <= sel_signed_c;
        end
    end

    // Sign-extend to the full product width so the low 2n bits are the exact product.
    always_comb begin
        a_ext_c = {{n{1'b0}}, s1_a};
        b_ext_c = {{n{1'b0}}, s1_b};
        if (s1_signed) begin
            a_ext_c = {{n{s1_a[n-1]}}, s1_a};
            b_ext_c = {{n{s1_b[n-1]}}, s1_b};
        end
    end
`else
    logic unused_signed;

    assign unused_signed = req0_signed ^ req1_signed;

    always_comb begin
        a_ext_c = {{n{1'b0}}, s1_a};
        b_ext_c = {{n{1'b0}}, s1_b};
    end
`endif

    assign prod_c = a_ext_c * b_ext_c;

    // Stage 1: capture the granted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_id <= grant1_c;
                s1_a  <= sel_a_c;
                s1_b  <= sel_b_c;
            end
        end
    end

    // Stage 2: register the product; id/data hold their last values between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_id   <= s1_id;
                res_data <= prod_c;
            end
        end
    end

endmodule
